// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// The optional inter-repetition gap is enabled with SERIAL_PATTERN_TX_GAP_EN.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_IDX_W = $clog2(DEFAULT_WIDTH);

    // Bit-index width for a given pattern length (WIDTH is at least 2).
    function automatic int idx_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam logic X_RST     = 1'b0;
    localparam logic VALID_RST = 1'b0;
    localparam logic BUSY_RST  = 1'b0;
    localparam logic DONE_RST  = 1'b0;

endpackage

// File: rtl/serial_pattern_shifter.sv
// Parallel-load, MSB-out shift register with a bit-index down-counter.
// Load takes priority over shift; last_bit is high while the index is 0.
module serial_pattern_shifter
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb,
    output logic             last_bit
);

    localparam int IDX_W = idx_width(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [IDX_W-1:0] idx;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= load_data;
            idx <= IDX_W'(WIDTH - 1);
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], 1'b0};
            if (idx != '0) begin
                idx <= idx - IDX_W'(1);
            end
        end
    end

    assign msb      = sr[WIDTH-1];
    assign last_bit = (idx == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first `count` times.
// Define SERIAL_PATTERN_TX_GAP_EN to insert GAP idle cycles between repetitions.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] count,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] GAP_S = ST_GAP;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] rep_cnt;
    logic [WIDTH-1:0] pat_q;
    logic             accept;
    logic             sh_load, sh_shift, sh_msb, sh_last;
    logic [WIDTH-1:0] sh_data;

`ifdef SERIAL_PATTERN_TX_GAP_EN
    logic [7:0] gap_cnt;
`else
    logic unused_gap_cfg;
    assign unused_gap_cfg = ^8'(GAP);
`endif

    assign accept  = (state == IDLE) && start && (count != '0);
    assign sh_data = accept ? pattern : pat_q;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count != '0) ? SHIFT : DONE;
                    sh_load    = (count != '0);
                end
            end
            SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    if (rep_cnt == CNT_W'(1)) begin
                        state_next = DONE;
                    end else begin
`ifdef SERIAL_PATTERN_TX_GAP_EN
                        state_next = GAP_S;
`else
                        sh_load = 1'b1;
`endif
                    end
                end
            end
            GAP_S: begin
`ifdef SERIAL_PATTERN_TX_GAP_EN
                if (gap_cnt == 8'd0) begin
                    state_next = SHIFT;
                    sh_load    = 1'b1;
                end
`else
                state_next = IDLE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rep_cnt <= '0;
            pat_q   <= '0;
            valid   <= VALID_RST;
            busy    <= BUSY_RST;
            done    <= DONE_RST;
        end else begin
            state <= state_next;
            valid <= (state_next == SHIFT);
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            if (accept) begin
                rep_cnt <= count;
                pat_q   <= pattern;
            end else if (state == SHIFT && sh_last) begin
                rep_cnt <= rep_cnt - CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_PATTERN_TX_GAP_EN
    // Loaded on the last bit so GAP lasts exactly GAP cycles (counts GAP-1 down to 0).
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= 8'd0;
        end else if (state == SHIFT && sh_last) begin
            gap_cnt <= 8'(GAP - 1);
        end else if (state == GAP_S && gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end
`endif

    serial_pattern_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_data (sh_data),
        .msb       (sh_msb),
        .last_bit  (sh_last)
    );

    assign x = valid ? sh_msb : X_RST;

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial pattern transmitter: latches a WIDTH-bit pattern on a start request and drives it MSB-first, one bit per clock, on the single-bit serial line `x`. It repeats the pattern a requested number of times, then reports completion. It is the stimulus/source end of the serial bit-stream interface consumed by the team's sequence detectors. It replaces hand-written `x` waveforms in benches and feeds detectors in loopback on-chip.

## Interface
Parameters:
- `WIDTH`, default 4: pattern length in bits; legal range 2..32.
- `CNT_W`, default 8: width of the repetition count.
- `GAP`, default 2: idle cycles between repetitions; used only with `SERIAL_PATTERN_TX_GAP_EN`; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: transmit request; sampled only in IDLE.
- `pattern`  in  WIDTH: bit sequence; bit WIDTH-1 is sent first.
- `count`  in  CNT_W: number of repetitions of `pattern`.
- `x`  out  1: serial data bit; 0 whenever `valid`=0.
- `valid`  out  1: `x` carries a pattern bit this cycle.
- `busy`  out  1: a transfer is in progress.
- `done`  out  1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: outputs 0.
  - SHIFT: `valid`=1, `busy`=1.
  - GAP: `valid`=0, `x`=0, `busy`=1.
  - DONE: `done`=1, `busy`=1.
- IDLE with `start`=1 and `count`≠0:
  - Latch `pattern` into the shift register and `count` into the repetition counter.
  - Load bit index WIDTH-1 and go to SHIFT.
- IDLE with `start`=1 and `count`=0: go directly to DONE. No bit is ever valid.
- SHIFT: `x` is the current MSB of the shift register. The register shifts left by one each cycle.
- At the end of WIDTH bits, decrement the repetition counter:
  - Counter reaches 0: go to DONE.
  - Otherwise, with the GAP macro: go to GAP.
  - Otherwise, without the GAP macro: reload the latched pattern and stay in SHIFT, with no bubble.
- GAP: lasts exactly `GAP` cycles, then reloads the pattern and returns to SHIFT.
- DONE: lasts one cycle, then goes to IDLE.
- `start` is ignored in SHIFT, GAP and DONE; there is no queuing.
- Changes to `pattern` or `count` after acceptance have no effect on the transfer in progress.
- Reset: `x`, `valid`, `busy` and `done` are 0 at the first edge with `reset`=1; all counters clear and the state goes to IDLE. Reset mid-transfer aborts the transfer without a `done` pulse.
- Reset and `start` high together: reset wins.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: `start` sampled at edge k → first bit (pattern[WIDTH-1]) on `x` with `valid`=1 in the cycle after edge k.
- One transfer (no gap): WIDTH×count consecutive `valid` cycles, then 1 DONE cycle, then IDLE.
- With gap: WIDTH×count + GAP×(count−1) cycles before DONE.
- `count`=0: `done` pulses in the cycle after the accepting edge.
- Back-to-back transfers: the earliest new `start` is accepted at the edge after DONE. The minimum dead time between transfers is 1 cycle of DONE plus 1 cycle of IDLE.
- Count saturation: `count`=2^CNT_W−1 must run to completion; the repetition counter must not wrap.

## Configuration
- `SERIAL_PATTERN_TX_GAP_EN` defined: the GAP state and a gap counter are compiled in. `GAP` idle cycles (`x`=0, `valid`=0, `busy`=1) are inserted between repetitions. No gap follows the last repetition.
- Not defined: GAP state and counter are absent. Repetitions are contiguous, and the `GAP` parameter is ignored.

## Structure
- Shared package `serial_pattern_tx_pkg`:
  - state enum: IDLE, SHIFT, GAP, DONE.
  - localparam for the bit-index width, $clog2(WIDTH).
  - reset-value constants for the outputs.
- One sub-module `serial_pattern_shifter`:
  - WIDTH-bit parallel-load, MSB-out shift register.
  - Has load/shift enables and a bit-index down-counter.
  - Asserts `last_bit` while the index is 0.
- The top-level module holds the FSM, the repetition counter and the gap counter.

## Test plan
- Basic: `pattern`=4'b1011, `count`=1, pulse `start` → `x`=1,0,1,1 on 4 consecutive `valid` cycles starting 1 cycle after `start`. `done` pulses on the 5th cycle, and `busy` falls on the 6th.
- Repeat, macro off: `pattern`=4'b1001, `count`=3 → 12 contiguous `valid` cycles carrying 1001 1001 1001, then `done`.
- Repeat, macro on, `GAP`=2: `pattern`=4'b1100, `count`=2 → 1100, 2 cycles with `valid`=0 and `x`=0, 1100, then `done`. Total 10 cycles before `done`.
- Zero count and ignored start: `count`=0 → `done` 1 cycle after `start` with `valid` never high. Then, during a `count`=2 transfer, pulse `start` and change `pattern` mid-transfer → output stream unchanged and no second transfer.
- Reset mid-transfer: assert `reset` on the 2nd bit of 4'b1111 → next cycle `x`/`valid`/`busy`/`done`=0 and no `done` pulse. After release, a new `start` with 4'b0110 transmits 0,1,1,0 correctly.
- Loopback: drive `x` into the team's Mealy sequence detector with its target pattern, `count`=2 → the detector output asserts exactly once per repetition.
